// File: rtl/axi_hdr_pkg.sv
// Shared types and constants for the AXI-Stream header generator.
package axi_hdr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        MODE_FIXED  = 2'd0,
        MODE_SWEEP  = 2'd1,
        MODE_RANDOM = 2'd2,
        MODE_RSVD   = 2'd3
    } mode_e;

    // Right-shifting Fibonacci form: taps 16,14,13,11 land on bits 0,2,3,5.
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

endpackage

// File: rtl/hdr_lfsr16.sv
// 16-bit Fibonacci LFSR; load restores the seed, advance takes one step.
module hdr_lfsr16
    import axi_hdr_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        advance,
    output logic [15:0] value
);

    logic [15:0] value_q;
    logic [15:0] value_d;

    always_comb begin
        value_d = value_q;
        if (load) begin
            value_d = LFSR_SEED;
        end else if (advance) begin
            value_d = {^(value_q & LFSR_TAPS), value_q[15:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q <= LFSR_SEED;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/axi_header_gen.sv
// Generates bursts of single-beat AXI-Stream headers with configurable byte
// counts (fixed, sweeping or LFSR-random) and optional idle gaps between them.
module axi_header_gen
    import axi_hdr_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int DATA_BYTE_WIDTH = DATA_WIDTH / 8,
    parameter int BYTE_CNT_WIDTH  = $clog2(DATA_BYTE_WIDTH),
    parameter int CNT_WIDTH       = 16,
    parameter int GAP_WIDTH       = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [1:0]                 mode,
    input  logic [CNT_WIDTH-1:0]       num_hdr,
    input  logic [GAP_WIDTH-1:0]       gap,
    input  logic [DATA_WIDTH-1:0]      seed_data,
    output logic                       valid,
    output logic [DATA_WIDTH-1:0]      data,
    output logic [DATA_BYTE_WIDTH-1:0] keep,
    output logic [BYTE_CNT_WIDTH-1:0]  byte_insert_cnt,
    input  logic                       ready,
    output logic                       busy,
    output logic                       done,
    output logic [CNT_WIDTH-1:0]       sent_cnt
);

    state_e                      state_q, state_d;
    mode_e                       mode_q, mode_d;
    logic [CNT_WIDTH-1:0]        num_q, num_d;
    logic [GAP_WIDTH-1:0]        gap_q, gap_d;
    logic [GAP_WIDTH-1:0]        gap_cnt_q, gap_cnt_d;
    logic [DATA_WIDTH-1:0]       data_q, data_d;
    logic [BYTE_CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0]        sent_q, sent_d;
    logic                        done_q, done_d;
    logic [CNT_WIDTH-1:0]        sent_nxt;
    logic                        lfsr_load;
    logic                        lfsr_adv;
    logic [15:0]                 lfsr_value;
    logic                        unused_lfsr_bits;

    hdr_lfsr16 u_lfsr (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (lfsr_load),
        .advance (lfsr_adv),
        .value   (lfsr_value)
    );

    assign unused_lfsr_bits = ^lfsr_value[15:BYTE_CNT_WIDTH];
    assign sent_nxt         = sent_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        num_d     = num_q;
        gap_d     = gap_q;
        gap_cnt_d = gap_cnt_q;
        data_d    = data_q;
        cnt_d     = cnt_q;
        sent_d    = sent_q;
        done_d    = 1'b0;
        lfsr_load = 1'b0;
        lfsr_adv  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mode_d    = mode_e'(mode);
                    num_d     = num_hdr;
                    gap_d     = gap;
                    data_d    = seed_data;
                    cnt_d     = '1;
                    sent_d    = '0;
                    lfsr_load = 1'b1;
                    if (num_hdr == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = ST_SEND;
                    end
                end
            end
            ST_SEND: begin
                if (ready) begin
                    sent_d   = sent_nxt;
                    data_d   = data_q + 1'b1;
                    lfsr_adv = 1'b1;
                    // Count is power-of-two wide, so 0 - 1 wraps to the top.
                    if (mode_q == MODE_SWEEP) begin
                        cnt_d = cnt_q - 1'b1;
                    end
                    if (sent_nxt == num_q) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else if (gap_q != '0) begin
                        state_d   = ST_GAP;
                        gap_cnt_d = gap_q - 1'b1;
                    end
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == '0) begin
                    state_d = ST_SEND;
                end else begin
                    gap_cnt_d = gap_cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            mode_q    <= MODE_FIXED;
            num_q     <= '0;
            gap_q     <= '0;
            gap_cnt_q <= '0;
            data_q    <= '0;
            cnt_q     <= '1;
            sent_q    <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            num_q     <= num_d;
            gap_q     <= gap_d;
            gap_cnt_q <= gap_cnt_d;
            data_q    <= data_d;
            cnt_q     <= cnt_d;
            sent_q    <= sent_d;
            done_q    <= done_d;
        end
    end

    assign valid           = (state_q == ST_SEND);
    assign busy            = (state_q != ST_IDLE);
    assign done            = done_q;
    assign data            = data_q;
    assign sent_cnt        = sent_q;
    assign byte_insert_cnt = (mode_q == MODE_RANDOM) ? lfsr_value[BYTE_CNT_WIDTH-1:0] : cnt_q;

    always_comb begin
        keep = '0;
        for (int i = 0; i < DATA_BYTE_WIDTH; i++) begin
            keep[i] = (i <= int'(byte_insert_cnt));
        end
    end

endmodule

// File: doc/axi_header_gen.md
AXI_HEADER_GEN -- requirements
Module: axi_header_gen

Interface
REQ-001 Parameter DATA_WIDTH, default 32: header beat width in bits; SHALL be a multiple of 16.
REQ-002 Parameter DATA_BYTE_WIDTH, default DATA_WIDTH/8: bytes per beat; SHALL be a power of two, at least 2.
REQ-003 Parameter BYTE_CNT_WIDTH, default $clog2(DATA_BYTE_WIDTH): width of byte_insert_cnt.
REQ-004 Parameter CNT_WIDTH, default 16: width of header count and sent counter.
REQ-005 Parameter GAP_WIDTH, default 8: width of inter-header idle gap.
REQ-006 clk  input  1  sole clock; all logic on posedge.
REQ-007 rst_n  input  1  asynchronous active-low reset.
REQ-008 start  input  1  one-cycle request to begin a burst; honoured only in IDLE.
REQ-009 mode  input  2  0 FIXED, 1 SWEEP, 2 RANDOM, 3 reserved (treated as FIXED); sampled at start.
REQ-010 num_hdr  input  CNT_WIDTH  headers in burst; sampled at start.
REQ-011 gap  input  GAP_WIDTH  idle cycles between headers; sampled at start.
REQ-012 seed_data  input  DATA_WIDTH  data of first header; sampled at start.
REQ-013 valid  output  1  AXI-Stream TVALID of header beat.
REQ-014 data  output  DATA_WIDTH  header payload.
REQ-015 keep  output  DATA_BYTE_WIDTH  right-aligned byte enables.
REQ-016 byte_insert_cnt  output  BYTE_CNT_WIDTH  valid bytes minus one.
REQ-017 ready  input  1  AXI-Stream TREADY from consumer.
REQ-018 busy  output  1  high in any state except IDLE.
REQ-019 done  output  1  one-cycle pulse on burst completion.
REQ-020 sent_cnt  output  CNT_WIDTH  headers accepted in current/last burst.

Function
REQ-021 FSM states SHALL be IDLE, SEND, GAP.
REQ-022 IDLE + start, num_hdr!=0: latch config, load data=seed_data, sent_cnt=0, LFSR=16'hACE1, go SEND; valid high the cycle after start.
REQ-023 IDLE + start, num_hdr==0: stay IDLE, valid never asserted, done pulses cycle after start, sent_cnt=0.
REQ-024 start outside IDLE SHALL be ignored; latched config unchanged for whole burst.
REQ-025 SEND: valid=1; data, keep, byte_insert_cnt SHALL hold stable while valid && !ready.
REQ-026 Handshake = valid && ready in same cycle; each handshake: sent_cnt+1, data+1 (modulo 2^DATA_WIDTH), count advanced per mode.
REQ-027 keep SHALL always equal (2^(byte_insert_cnt+1))-1; valid never deasserted without handshake.
REQ-028 FIXED: byte_insert_cnt = DATA_BYTE_WIDTH-1 for every header.
REQ-029 SWEEP: first header DATA_BYTE_WIDTH-1, decrement per handshake, wrap 0 -> DATA_BYTE_WIDTH-1.
REQ-030 RANDOM: 16-bit Fibonacci LFSR, taps 16,14,13,11; byte_insert_cnt = LFSR[BYTE_CNT_WIDTH-1:0]; LFSR advances one step per handshake only.
REQ-031 Handshake on header num_hdr: go IDLE, valid low next cycle, done pulse next cycle.
REQ-032 Non-last handshake, gap==0: stay SEND, next header presented next cycle (back-to-back, full throughput).
REQ-033 Non-last handshake, gap!=0: go GAP, valid low exactly gap cycles, then SEND.
REQ-034 sent_cnt SHALL hold after burst until next accepted start.

Reset
REQ-035 rst_n low SHALL immediately force: IDLE, valid=0, busy=0, done=0, sent_cnt=0, data=0, keep all ones, byte_insert_cnt all ones, LFSR=16'hACE1.
REQ-036 Reset mid-burst SHALL abort burst without done pulse; release returns to IDLE awaiting start.

Structure
REQ-037 Package axi_hdr_pkg SHALL hold state enum, mode enum, LFSR seed and tap constants.
REQ-038 LFSR SHALL be sub-module hdr_lfsr16 (clk, rst_n, load, advance, value).

Verification
REQ-039 FIXED, num_hdr=3, gap=0, seed=32'h0000_0010, ready=1: data 0x10,0x11,0x12 consecutive cycles, keep 4'hF, done one cycle after third, sent_cnt=3.
REQ-040 SWEEP, num_hdr=6, gap=0: byte_insert_cnt 3,2,1,0,3,2; keep F,7,3,1,F,7.
REQ-041 FIXED, num_hdr=2, gap=2: valid pattern 1,0,0,1 with ready=1.
REQ-042 ready low 5 cycles mid-burst: outputs stable, sent_cnt unchanged, burst resumes on ready.
REQ-043 num_hdr=0: no valid, done one cycle after start; start during busy: ignored.
REQ-044 rst_n low during GAP of 4-header burst: outputs to reset values, no done; new start runs full burst.
